// File: rtl/reg_bank_cnt.sv
// reg_bank_cnt: bank of NUM_REGS counters, WIDTH bits each.
// Each register can be loaded from the store bus or incremented in place.
// One register at a time drives the load bus.
// CARRY is a one-cycle pulse that follows an increment which wrapped from all-ones to zero.
module reg_bank_cnt #(
    parameter int                 WIDTH     = 4,
    parameter int                 NUM_REGS  = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_st_en,
    input  logic [SEL_W-1:0]             i_st_sel,
    input  logic [WIDTH-1:0]             i_st_data,
    input  logic                         i_inc_en,
    input  logic [SEL_W-1:0]             i_inc_sel,
    input  logic                         i_out_en,
    input  logic [SEL_W-1:0]             i_out_sel,
    output logic [WIDTH-1:0]             o_ld_data,
    output logic                         o_ld_drv,
    output logic                         o_carry,
    output logic [NUM_REGS*WIDTH-1:0]    o_regs_q
);

    // A single-entry bank ignores its selects.
    // Otherwise an out-of-range select matches no entry, so the access is dropped.
    function automatic logic sel_hit(input logic [SEL_W-1:0] sel, input int idx);
        return (NUM_REGS == 1) || (sel == SEL_W'(idx));
    endfunction

    logic [WIDTH-1:0]    r_regs [NUM_REGS];
    logic                r_carry;
    logic [NUM_REGS-1:0] w_st_hit;
    logic [NUM_REGS-1:0] w_inc_hit;
    logic [NUM_REGS-1:0] w_wrap;
    logic [NUM_REGS-1:0] w_rd_hit;
    logic [WIDTH-1:0]    w_ld_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign w_st_hit[gi]  = i_st_en && sel_hit(i_st_sel, gi);
            // A store to the same entry takes priority over an increment.
            assign w_inc_hit[gi] = i_inc_en && sel_hit(i_inc_sel, gi) && !w_st_hit[gi];
            assign w_wrap[gi]    = w_inc_hit[gi] && (&r_regs[gi]);
            assign w_rd_hit[gi]  = i_out_en && sel_hit(i_out_sel, gi);
            assign o_regs_q[gi*WIDTH +: WIDTH] = r_regs[gi];

            // Per-entry state: store, else increment, else hold.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_regs[gi] <= RESET_VAL;
                end else if (w_st_hit[gi]) begin
                    r_regs[gi] <= i_st_data;
                end else if (w_inc_hit[gi]) begin
                    r_regs[gi] <= r_regs[gi] + WIDTH'(1);
                end
            end
        end
    endgenerate

    // The carry pulse is set only by a wrapping increment; every other cycle clears it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_carry <= 1'b0;
        end else begin
            r_carry <= |w_wrap;
        end
    end

    // Load-bus read mux: zero when disabled or when the select is out of range.
    always_comb begin
        w_ld_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_hit[i]) begin
                w_ld_data = r_regs[i];
            end
        end
    end

    assign o_ld_data = w_ld_data;
    assign o_ld_drv  = i_out_en;
    assign o_carry   = r_carry;

endmodule
